// File: rtl/seq_arith_unit_if.sv
// Operand/result handshake bundle for seq_arith_unit.
// The slave modport is the arithmetic unit; the master modport is its producer/consumer.
interface seq_arith_unit_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 busy;

  modport master (
    output in_valid, op_a, op_b, mode, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, mode, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/seq_arith_unit.sv
// Sequential add / shift-add multiply unit with valid/ready handshakes on both sides.
// Add completes in one cycle; multiply takes exactly WIDTH cycles regardless of data.
module seq_arith_unit #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_arith_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]     b_sh_q, b_sh_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   acc_step_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= {(2*WIDTH){1'b0}};
      a_sh_q   <= {(2*WIDTH){1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      result_q <= {(2*WIDTH){1'b0}};
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    sum_s      = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    // This step's add is folded in so the last iteration can write result directly.
    acc_step_s = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.mode) begin
            acc_d   = {(2*WIDTH){1'b0}};
            a_sh_d  = {{WIDTH{1'b0}}, bus.op_a};
            b_sh_d  = bus.op_b;
            cnt_d   = {CW{1'b0}};
            state_d = MUL;
          end else begin
            result_d = {{(WIDTH-1){1'b0}}, sum_s};
            state_d  = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d  = acc_step_s;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = acc_step_s;
          state_d  = DONE;
        end else begin
          state_d = MUL;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == MUL);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Bench for seq_arith_unit: directed vector table, mid-multiply reset, exhaustive
// WIDTH=3 sweep and random WIDTH=4 traffic checked against a transaction-level model.
module tb_seq_arith_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  seq_arith_unit_if #(.WIDTH(4)) if4 ();
  seq_arith_unit_if #(.WIDTH(3)) if3 ();

  seq_arith_unit #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  seq_arith_unit #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          m;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [7:0]  exp_res;
    int          stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ov(input bit s);
    return s ? if3.out_valid : if4.out_valid;
  endfunction

  function automatic logic rdy(input bit s);
    return s ? if3.in_ready : if4.in_ready;
  endfunction

  function automatic logic bsy(input bit s);
    return s ? if3.busy : if4.busy;
  endfunction

  function automatic logic [7:0] res(input bit s);
    return s ? {2'b00, if3.result} : if4.result;
  endfunction

  task automatic drive(input bit s, input logic v, input logic m, input logic [3:0] a, input logic [3:0] b);
    if (s) begin
      if3.in_valid = v; if3.mode = m; if3.op_a = a[2:0]; if3.op_b = b[2:0];
    end else begin
      if4.in_valid = v; if4.mode = m; if4.op_a = a;      if4.op_b = b;
    end
  endtask

  task automatic set_ordy(input bit s, input logic v);
    if (s) if3.out_ready = v;
    else   if4.out_ready = v;
  endtask

  // One transaction: expected latency and busy span come from the mode and width alone.
  task automatic run_op(input bit s, input bit m, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_res, input int stall);
    int k;
    int nbusy;
    int w;
    w = s ? 3 : 4;
    chk("in_ready_before_accept", {31'd0, rdy(s)}, 32'd1);
    drive(s, 1'b1, m, a, b);
    set_ordy(s, (stall == 0));
    @(posedge clk);
    @(negedge clk);
    drive(s, 1'b0, 1'b0, 4'd15, 4'd15);
    k = 0;
    nbusy = 0;
    while (!ov(s) && k < 40) begin
      if (bsy(s)) nbusy++;
      @(negedge clk);
      k++;
    end
    chk("latency", k, m ? w : 0);
    chk("busy_cycles", nbusy, m ? w : 0);
    chk("result", {24'd0, res(s)}, {24'd0, exp_res});
    for (int i = 0; i < stall; i++) begin
      drive(s, 1'b1, 1'b0, 4'd1, 4'd1);
      @(negedge clk);
      chk("stall_result", {24'd0, res(s)}, {24'd0, exp_res});
      chk("stall_out_valid", {31'd0, ov(s)}, 32'd1);
      chk("stall_in_ready", {31'd0, rdy(s)}, 32'd0);
    end
    drive(s, 1'b0, 1'b0, 4'd0, 4'd0);
    set_ordy(s, 1'b1);
    @(negedge clk);
    chk("out_valid_after_handshake", {31'd0, ov(s)}, 32'd0);
    chk("in_ready_after_handshake", {31'd0, rdy(s)}, 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    logic [3:0] ra, rb;
    bit         rm;
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{1'b0, 4'd9,  4'd8,  8'h11, 0};
    vecs[1] = '{1'b1, 4'd15, 4'd15, 8'hE1, 0};
    vecs[2] = '{1'b1, 4'd0,  4'd13, 8'h00, 0};
    vecs[3] = '{1'b1, 4'd13, 4'd0,  8'h00, 0};
    vecs[4] = '{1'b1, 4'd6,  4'd7,  8'h2A, 5};
    vecs[5] = '{1'b0, 4'd1,  4'd1,  8'h02, 0};
    vecs[6] = '{1'b0, 4'd7,  4'd1,  8'h08, 0};
    vecs[7] = '{1'b1, 4'd6,  4'd7,  8'h2A, 0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    set_ordy(1'b0, 1'b1);
    set_ordy(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("reset_in_ready", {31'd0, if4.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, if4.out_valid}, 32'd0);
    chk("reset_busy", {31'd0, if4.busy}, 32'd0);
    chk("reset_result", {24'd0, if4.result}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(1'b0, vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].stall);

    // Reset asserted in the second multiply cycle must abandon the operation at once.
    drive(1'b0, 1'b1, 1'b1, 4'd11, 4'd13);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    chk("busy_before_reset", {31'd0, if4.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_reset_out_valid", {31'd0, if4.out_valid}, 32'd0);
    chk("midop_reset_in_ready", {31'd0, if4.in_ready}, 32'd1);
    chk("midop_reset_busy", {31'd0, if4.busy}, 32'd0);
    chk("midop_reset_result", {24'd0, if4.result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, 1'b1, 4'd3, 4'd5, 8'd15, 0);

    // Exhaustive WIDTH=3 sweep against plain arithmetic.
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          run_op(1'b1, m[0], a[3:0], b[3:0], (m != 0) ? 8'(a * b) : 8'(a + b), 0);

    // Random WIDTH=4 traffic with occasional backpressure.
    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      run_op(1'b0, rm, ra, rb, rm ? 8'(int'(ra) * int'(rb)) : 8'(int'(ra) + int'(rb)),
             int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
